// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction prefetch front end: FSM encodings and
// the field layout of a prefetch FIFO entry {pc, data, fault}.
package ifu_pkg;

    typedef enum logic [0:0] {
        IfuStRun   = 1'b0,
        IfuStFault = 1'b1
    } ifu_state_e;

    // Entry layout, LSB first: fault bit, then instruction word, then PC.
    localparam int unsigned IfuFaultBit = 0;
    localparam int unsigned IfuDataLsb  = 1;

    function automatic int unsigned ifu_pc_lsb(input int unsigned xlen);
        return IfuDataLsb + xlen;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO with single-cycle flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push at full is legal then.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch front end: sequential fetch, PC-tagged prefetch FIFO, redirect flush.
// Define IFU_MISALIGN_EN to trap misaligned redirect targets in a FAULT state.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_instr_valid,
    input  logic            mem_instr_ready,
    output logic [XLEN-1:0] mem_instr_addr,
    input  logic [XLEN-1:0] mem_instr_data,
    input  logic            mem_instr_resp,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_fault
);

    localparam int unsigned EntryW = 2 * XLEN + 1;
    localparam int unsigned PcLsb  = ifu_pc_lsb(XLEN);
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SumW   = CntW + 1;

    logic              run_en_q;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
    logic [CntW-1:0]   inflight_q, inflight_d;
    logic [CntW-1:0]   drop_q, drop_d;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [EntryW-1:0] fifo_wdata;
    logic [EntryW-1:0] fifo_rdata;
    logic [XLEN-1:0]   tgt_pc;
    logic [SumW-1:0]   credit_sum;
    logic              in_run;
    logic              fault_push;
    logic              accept;
    logic              resp_ok;
    logic              resp_keep;

`ifdef IFU_MISALIGN_EN
    ifu_state_e state_q, state_d;
    logic       tgt_misalign;

    assign tgt_misalign = (redirect_pc[1:0] != 2'b00);
    assign tgt_pc       = redirect_pc;
    assign in_run       = (state_q == IfuStRun);
    // The flush empties the FIFO, so "empty in FAULT" means the marker is not yet pushed.
    assign fault_push   = !in_run && fifo_empty && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IfuStRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = tgt_misalign ? IfuStFault : IfuStRun;
        end
    end

    assign instr_fault = !fifo_empty && fifo_rdata[IfuFaultBit];
`else
    logic unused_fault_bit;

    assign tgt_pc           = redirect_pc & ~XLEN'(3);
    assign in_run           = 1'b1;
    assign fault_push       = 1'b0;
    assign instr_fault      = 1'b0;
    assign unused_fault_bit = fifo_rdata[IfuFaultBit];
`endif

    always_comb begin
        credit_sum      = SumW'(fifo_count) + SumW'(inflight_q);
        // Counting in-flight requests against free slots guarantees every response has room.
        mem_instr_valid = run_en_q && in_run && !redirect_valid
                          && (inflight_q < CntW'(MAX_OUTSTANDING))
                          && (credit_sum < SumW'(FIFO_DEPTH));
        accept          = mem_instr_valid && mem_instr_ready;
        resp_ok         = mem_instr_resp && ((inflight_q != '0) || accept);
        resp_keep       = resp_ok && (drop_q == '0) && !redirect_valid && in_run;

        inflight_d = inflight_q + CntW'(accept) - CntW'(resp_ok);
        drop_d     = drop_q;
        if (resp_ok && (drop_q != '0)) begin
            drop_d = drop_q - CntW'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        resp_pc_d = resp_pc_q;
        if (resp_keep) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
        end

        if (redirect_valid) begin
            fetch_pc_d = tgt_pc;
            resp_pc_d  = tgt_pc;
            drop_d     = inflight_d;
        end

        fifo_push                       = resp_keep || fault_push;
        fifo_wdata                      = '0;
        fifo_wdata[PcLsb +: XLEN]       = resp_pc_q;
        if (fault_push) begin
            fifo_wdata[IfuFaultBit]     = 1'b1;
        end else begin
            fifo_wdata[IfuDataLsb +: XLEN] = mem_instr_data;
        end

        instr_valid = !fifo_empty && !redirect_valid;
        // The fault marker stays at the head until the next redirect.
        fifo_pop    = instr_valid && instr_ready && in_run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en_q   <= 1'b0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            run_en_q   <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    assign mem_instr_addr = fetch_pc_q;
    assign instr_data     = fifo_empty ? '0 : fifo_rdata[IfuDataLsb +: XLEN];
    assign instr_pc       = fifo_empty ? '0 : fifo_rdata[PcLsb +: XLEN];

    ifu_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: memory model with same-cycle or 2-cycle responses,
// decode-side scoreboard, redirect vector table and hand-written corner sequences.
module tb_ifu_prefetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_instr_valid;
    logic        mem_instr_ready;
    logic [31:0] mem_instr_addr;
    logic [31:0] mem_instr_data;
    logic        mem_instr_resp;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_fault;

    logic        mode_same;
    logic        p1, p2;
    logic [31:0] a1, a2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          acc_cnt  = 0;
    int          pop_cnt  = 0;
    logic [31:0] last_acc_addr = 32'h0;
    logic [31:0] exp_fetch = 32'h0;
    logic        fault_mode = 1'b0;
    exp_t        sb[$];
    vec_t        vecs[$];

    ifu_prefetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mem_instr_valid (mem_instr_valid),
        .mem_instr_ready (mem_instr_ready),
        .mem_instr_addr  (mem_instr_addr),
        .mem_instr_data  (mem_instr_data),
        .mem_instr_resp  (mem_instr_resp),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .instr_fault     (instr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data = addr + 0x100, answered in the accept cycle or two cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
            a1 <= 32'h0;
            a2 <= 32'h0;
        end else begin
            p1 <= mem_instr_valid && mem_instr_ready && !mode_same;
            a1 <= mem_instr_addr;
            p2 <= p1;
            a2 <= a1;
        end
    end

    assign mem_instr_resp = mode_same ? (mem_instr_valid && mem_instr_ready) : p2;
    assign mem_instr_data = mode_same ? (mem_instr_addr + 32'h100) : (a2 + 32'h100);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cyc();
        redirect_valid = 1'b0;
    endtask

    task automatic redir_check(input string name, input logic [31:0] rpc, input logic [31:0] epc);
        bit got;
        got = 1'b0;
        do_redirect(rpc);
        #3;
        check({name, "_req_valid"}, 32'(mem_instr_valid), 32'd1);
        check({name, "_req_addr"}, mem_instr_addr, epc);
        for (int i = 0; i < 12 && !got; i++) begin
            cyc();
            #3;
            got = instr_valid;
        end
        check({name, "_timeout"}, 32'(got), 32'd1);
        check({name, "_pc"}, instr_pc, epc);
        check({name, "_fault"}, 32'(instr_fault), 32'd0);
    endtask

    // Scoreboard: expectations pushed per accepted request, popped per decode handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                exp_fetch  = 32'h0;
                fault_mode = 1'b0;
            end else begin
                if (instr_valid && instr_ready && !fault_mode) begin
                    pop_cnt++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_underflow: popped pc %h, expected no entry", instr_pc);
                    end else begin
                        e = sb.pop_front();
                        check("sb_pc", instr_pc, e.pc);
                        check("sb_data", instr_data, e.data);
                        check("sb_fault", 32'(instr_fault), 32'd0);
                    end
                end
                if (redirect_valid) begin
                    sb.delete();
`ifdef IFU_MISALIGN_EN
                    fault_mode = (redirect_pc[1:0] != 2'b00);
                    exp_fetch  = redirect_pc;
`else
                    exp_fetch  = redirect_pc & 32'hFFFF_FFFC;
`endif
                end
                if (mem_instr_valid && mem_instr_ready) begin
                    acc_cnt++;
                    last_acc_addr = mem_instr_addr;
                    if (fault_mode) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL req_in_fault: got request %h, expected none", mem_instr_addr);
                    end
                    check("req_addr", mem_instr_addr, exp_fetch);
                    sb.push_back('{pc: exp_fetch, data: exp_fetch + 32'h100});
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        bit got;

        vecs.push_back('{name: "rd_1000", rpc: 32'h0000_1000, exp_pc: 32'h0000_1000});
        vecs.push_back('{name: "rd_wrap", rpc: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8});
        vecs.push_back('{name: "rd_0040", rpc: 32'h0000_0040, exp_pc: 32'h0000_0040});
`ifndef IFU_MISALIGN_EN
        vecs.push_back('{name: "rd_0202", rpc: 32'h0000_0202, exp_pc: 32'h0000_0200});
        vecs.push_back('{name: "rd_0303", rpc: 32'h0000_0303, exp_pc: 32'h0000_0300});
`endif

        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        mem_instr_ready = 1'b1;
        instr_ready     = 1'b1;
        mode_same       = 1'b1;

        // Reset values
        #2;
        check("rst_req_valid", 32'(mem_instr_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_fault", 32'(instr_fault), 32'd0);
        check("rst_instr_data", instr_data, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // Sequential fetch with same-cycle responses
        cyc();
        cyc();
        rst_n = 1'b1;
        repeat (12) cyc();
        check("run_accepts", 32'(acc_cnt >= 4), 32'd1);
        check("run_pops", 32'(pop_cnt >= 4), 32'd1);

        // Decode stalled: FIFO fills, one pop frees exactly one request
        instr_ready = 1'b0;
        do_redirect(32'h0);
        repeat (7) cyc();
        #3;
        check("fill_req_idle", 32'(mem_instr_valid), 32'd0);
        check("fill_valid", 32'(instr_valid), 32'd1);
        check("fill_head_pc", instr_pc, 32'h0);
        check("fill_head_data", instr_data, 32'h100);
        cyc();
        instr_ready = 1'b1;
        a0 = acc_cnt;
        cyc();
        instr_ready = 1'b0;
        repeat (5) cyc();
        #3;
        check("refill_count", 32'(acc_cnt - a0), 32'd1);
        check("refill_addr", last_acc_addr, 32'h10);
        check("refill_head_pc", instr_pc, 32'h4);

        // Arbiter back-pressure: request and address held
        instr_ready = 1'b1;
        do_redirect(32'h0);
        cyc();
        cyc();
        mem_instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            check("stall_valid", 32'(mem_instr_valid), 32'd1);
            check("stall_addr", mem_instr_addr, 32'h8);
            if (i > 0) begin
                check("stall_no_push", 32'(instr_valid), 32'd0);
            end
            cyc();
        end
        mem_instr_ready = 1'b1;
        repeat (4) cyc();

        // Redirect vector table
        foreach (vecs[i]) begin
            redir_check(vecs[i].name, vecs[i].rpc, vecs[i].exp_pc);
            repeat (3) cyc();
        end

`ifdef IFU_MISALIGN_EN
        // Misaligned redirect: single held fault marker, no requests
        do_redirect(32'h0000_0202);
        #3;
        check("flt_no_req", 32'(mem_instr_valid), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            cyc();
            #3;
            got = instr_valid;
        end
        check("flt_timeout", 32'(got), 32'd1);
        check("flt_fault", 32'(instr_fault), 32'd1);
        check("flt_pc", instr_pc, 32'h0000_0202);
        check("flt_data", instr_data, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #3;
            check("flt_hold_valid", 32'(instr_valid), 32'd1);
            check("flt_hold_pc", instr_pc, 32'h0000_0202);
            check("flt_hold_req", 32'(mem_instr_valid), 32'd0);
        end
        cyc();
        redir_check("flt_exit", 32'h0000_0300, 32'h0000_0300);
        repeat (3) cyc();
`endif

        // Delayed responses dropped across a redirect
        mode_same = 1'b0;
        do_redirect(32'h0000_0100);
        cyc();
        redir_check("late_drop", 32'h0000_0200, 32'h0000_0200);
        repeat (4) cyc();

        // Asynchronous reset with entries buffered and requests in flight
        instr_ready = 1'b0;
        do_redirect(32'h0000_0400);
        repeat (5) cyc();
        #3;
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        check("pre_rst_pc", instr_pc, 32'h0000_0400);
        cyc();
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", 32'(mem_instr_valid), 32'd0);
        check("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_fault", 32'(instr_fault), 32'd0);
        check("mid_rst_data", instr_data, 32'h0);
        check("mid_rst_pc", instr_pc, 32'h0);
        mode_same   = 1'b1;
        instr_ready = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            cyc();
            #3;
            got = mem_instr_valid;
        end
        check("post_rst_timeout", 32'(got), 32'd1);
        check("post_rst_addr", mem_instr_addr, 32'h0);
        repeat (6) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
